rx_iq_packer: RTL

//  Receive-path stage between the AD9361 1T1R interface (12-bit rx_I/rx_Q plus rx_ce) and the AXI2S stream input (Sin/Ien).

---
 rtl/rx_iq_packer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/rx_iq_packer.sv
// rx_iq_packer: receive-path stage between the AD9361 1T1R sample interface
// and the AXI2S stream input. Decimates the rx_ce sample stream, packs kept
// samples into 32-bit words (16b I/Q, 8b I/Q pairs, or a counter test
// pattern) and emits one-cycle word strobes with a start-of-frame marker.
module rx_iq_packer #(
    parameter int DEC_W = 4,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic [DEC_W-1:0] dec,
    input  logic             sync,
    input  logic [11:0]      rx_I,
    input  logic [11:0]      rx_Q,
    input  logic             rx_ce,
    output logic [31:0]      dout,
    output logic             dout_en,
    output logic             dout_sof,
    output logic [CNT_W-1:0] word_cnt
);

    localparam logic [1:0] MODE_IQ16 = 2'd0;
    localparam logic [1:0] MODE_IQ8  = 2'd1;
    localparam logic [1:0] MODE_TEST = 2'd2;

    logic [1:0]       mode_r;
    logic [DEC_W-1:0] dec_cnt;
    logic             phase;
    logic [15:0]      lo;
    logic [CNT_W-1:0] test_cnt;
    logic             sof_pend;

    // Combinational view of the current cycle
    logic [1:0]       mode_eff;
    logic             accept;
    logic             kept;
    logic             phase_eff;
    logic [CNT_W-1:0] tc_eff;
    logic [CNT_W-1:0] wc_eff;
    logic             sofp_eff;
    logic [31:0]      s16;
    logic [15:0]      s8;
    logic             emit;
    logic [31:0]      word;
    logic [DEC_W-1:0] dec_nxt;

    // Mode 3 is an alias of mode 0
    assign mode_eff = (mode_r == 2'd3) ? MODE_IQ16 : mode_r;

    assign accept = enable & rx_ce & ~sync;
    // A sync cycle with rx_ce is always sample 0 of the new alignment
    assign kept   = enable & rx_ce & (sync | (dec_cnt == '0));

    // On sync the sample of that cycle sees fully cleared pack/frame state
    assign phase_eff = sync ? 1'b0 : phase;
    assign tc_eff    = sync ? '0 : test_cnt;
    assign wc_eff    = sync ? '0 : word_cnt;
    assign sofp_eff  = sync ? 1'b1 : sof_pend;

    assign s16 = {{4{rx_Q[11]}}, rx_Q, {4{rx_I[11]}}, rx_I};
    assign s8  = {rx_Q[11:4], rx_I[11:4]};

    // Word assembly and strobe decision per mode
    always_comb begin
        emit = 1'b0;
        word = s16;
        case (mode_eff)
            MODE_IQ8: begin
                emit = kept & phase_eff;
                word = {s8, lo};
            end
            MODE_TEST: begin
                emit = kept;
                word = 32'(tc_eff);
            end
            default: begin
                emit = kept;
                word = s16;
            end
        endcase
    end

    // Decimation counter next value; the sync sample counts as the first
    // accept from zero so dec=0 keeps every sample right after a sync
    always_comb begin
        dec_nxt = dec_cnt;
        if (sync) begin
            if (rx_ce)
                dec_nxt = (dec == '0) ? '0 : DEC_W'(1);
            else
                dec_nxt = '0;
        end else if (accept) begin
            dec_nxt = (dec_cnt == dec) ? '0 : dec_cnt + DEC_W'(1);
        end
    end

    // Mode is only taken while idle so a running stream never changes format
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mode_r <= MODE_IQ16;
        else if (!enable)
            mode_r <= mode;
    end

    // Decimation alignment and 8-bit pair packing state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_cnt <= '0;
            phase   <= 1'b0;
            lo      <= '0;
        end else if (!enable) begin
            dec_cnt <= '0;
            phase   <= 1'b0;
        end else begin
            dec_cnt <= dec_nxt;
            if (kept && mode_eff == MODE_IQ8) begin
                phase <= ~phase_eff;
                if (!phase_eff)
                    lo <= s8;
            end else if (sync) begin
                phase <= 1'b0;
            end
        end
    end

    // Frame counters: test pattern, emitted words and pending start-of-frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            test_cnt <= '0;
            word_cnt <= '0;
            sof_pend <= 1'b1;
        end else if (enable) begin
            if (kept && mode_eff == MODE_TEST)
                test_cnt <= tc_eff + CNT_W'(1);
            else if (sync)
                test_cnt <= '0;

            if (emit) begin
                word_cnt <= wc_eff + CNT_W'(1);
                sof_pend <= 1'b0;
            end else if (sync) begin
                word_cnt <= '0;
                sof_pend <= 1'b1;
            end
        end
    end

    // Output register: fixed one-cycle latency from the completing sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout     <= '0;
            dout_en  <= 1'b0;
            dout_sof <= 1'b0;
        end else begin
            dout_en  <= emit;
            dout_sof <= emit & sofp_eff;
            if (emit)
                dout <= word;
        end
    end

endmodule
